// File: rtl/seq_player.sv
// Taglist sequence player: fetches start/end/last entries from a synchronous
// RAM and steps a playback address through the selected sequence.
module seq_player #(
  parameter int ADDR_W  = 10,
  parameter int TAG_AW  = 7,
  parameter int RAM_LAT = 1,
  localparam int ENTRY_W = 2*ADDR_W+1
) (
  input  logic               clock_n,
  input  logic               reset,
  input  logic [ENTRY_W-1:0] data_in,
  input  logic               pb_seq_up,
  input  logic               pb_seq_dn,
  input  logic [1:0]         mode,
  input  logic               pause,
  output logic [TAG_AW-1:0]  ram_counter,
  output logic [ADDR_W-1:0]  addr,
  output logic               load,
  output logic               addr_inc,
  output logic               at_end,
  output logic               seq_wrap,
  output logic               done
);

  typedef enum logic [1:0] {
    S_FETCH, S_LOAD, S_PLAY, S_HOLD
  } state_t;

  localparam logic [1:0]        LAT_M1   = 2'(RAM_LAT-1);
  localparam logic [TAG_AW-1:0] IDX_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              r_state, w_state_nx;
  logic [1:0]          r_cnt;
  logic [TAG_AW-1:0]   r_idx, w_idx_nx;
  logic [TAG_AW-1:0]   r_last_idx;
  logic                r_last_valid;
  logic [ADDR_W-1:0]   r_start, r_end;
  logic                r_last;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic                r_done, w_done_nx;
  logic                r_wrap, w_wrap_nx;
  logic                r_up1, r_up2, r_dn1, r_dn2;
  logic                r_pu, r_pd, w_pu_nx, w_pd_nx;
  logic                w_cap, w_inc, w_eq;
  logic                w_up_req, w_dn_req, w_go_up, w_go_dn;
  logic [ADDR_W-1:0]   w_start, w_end_raw, w_end_c;
  logic [TAG_AW-1:0]   w_up_idx, w_dn_idx;
  logic                w_up_wrap, w_dn_wrap;

  assign w_start   = data_in[2*ADDR_W:ADDR_W+1];
  assign w_end_raw = data_in[ADDR_W:1];
  // Malformed entries collapse to a single address
  assign w_end_c   = (w_end_raw < w_start) ? w_start : w_end_raw;

  assign w_up_req = r_up1 & ~r_up2 & ~(r_dn1 & ~r_dn2);
  assign w_dn_req = r_dn1 & ~r_dn2 & ~(r_up1 & ~r_up2);
  assign w_go_up  = w_up_req | (r_pu & ~w_dn_req);
  assign w_go_dn  = w_dn_req | (r_pd & ~w_up_req);
  assign w_eq     = (r_addr == r_end);

  always_comb begin
    w_up_idx  = r_idx + IDX_ONE;
    w_up_wrap = 1'b0;
    if (r_last || (&r_idx)) begin
      w_up_idx  = '0;
      w_up_wrap = 1'b1;
    end
    w_dn_idx  = r_idx - IDX_ONE;
    w_dn_wrap = 1'b0;
    if (r_idx == '0) begin
      w_dn_idx  = r_last_valid ? r_last_idx : '0;
      w_dn_wrap = r_last_valid;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_addr_nx  = r_addr;
    w_done_nx  = r_done;
    w_wrap_nx  = 1'b0;
    w_pu_nx    = r_pu;
    w_pd_nx    = r_pd;
    w_cap      = 1'b0;
    w_inc      = 1'b0;
    unique case (r_state)
      S_FETCH, S_LOAD: begin
        if (w_up_req) begin
          w_pu_nx = 1'b1;
          w_pd_nx = 1'b0;
        end else if (w_dn_req) begin
          w_pu_nx = 1'b0;
          w_pd_nx = 1'b1;
        end
        if (r_state == S_LOAD) begin
          w_state_nx = pause ? S_HOLD : S_PLAY;
        end else if (r_cnt == LAT_M1) begin
          w_cap      = 1'b1;
          w_addr_nx  = w_start;
          w_state_nx = S_LOAD;
        end
      end
      S_PLAY, S_HOLD: begin
        w_pu_nx = 1'b0;
        w_pd_nx = 1'b0;
        if (w_go_up) begin
          w_idx_nx   = w_up_idx;
          w_wrap_nx  = w_up_wrap;
          w_done_nx  = 1'b0;
          w_state_nx = S_FETCH;
        end else if (w_go_dn) begin
          w_idx_nx   = w_dn_idx;
          w_wrap_nx  = w_dn_wrap;
          w_done_nx  = 1'b0;
          w_state_nx = S_FETCH;
        end else if (r_state == S_HOLD) begin
          if (!r_done && !pause) w_state_nx = S_PLAY;
        end else if (!pause) begin
          if (!w_eq) begin
            w_inc     = 1'b1;
            w_addr_nx = r_addr + ADDR_ONE;
          end else begin
            unique case (mode)
              2'b00: w_addr_nx = r_start;
              2'b01: begin
                w_state_nx = S_HOLD;
                w_done_nx  = 1'b1;
              end
              2'b10: begin
                w_idx_nx   = w_up_idx;
                w_wrap_nx  = w_up_wrap;
                w_state_nx = S_FETCH;
              end
              2'b11: begin
                if (r_last) begin
                  w_state_nx = S_HOLD;
                  w_done_nx  = 1'b1;
                end else begin
                  w_idx_nx   = w_up_idx;
                  w_wrap_nx  = w_up_wrap;
                  w_state_nx = S_FETCH;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_n) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_last_idx   <= '0;
      r_last_valid <= 1'b0;
      r_start      <= '0;
      r_end        <= '0;
      r_last       <= 1'b0;
      r_addr       <= '0;
      r_done       <= 1'b0;
      r_wrap       <= 1'b0;
      r_up1        <= 1'b0;
      r_up2        <= 1'b0;
      r_dn1        <= 1'b0;
      r_dn2        <= 1'b0;
      r_pu         <= 1'b0;
      r_pd         <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= (r_state == S_FETCH && w_state_nx == S_FETCH) ?
                 r_cnt + 2'd1 : 2'd0;
      r_idx   <= w_idx_nx;
      r_addr  <= w_addr_nx;
      r_done  <= w_done_nx;
      r_wrap  <= w_wrap_nx;
      r_pu    <= w_pu_nx;
      r_pd    <= w_pd_nx;
      r_up1   <= pb_seq_up;
      r_up2   <= r_up1;
      r_dn1   <= pb_seq_dn;
      r_dn2   <= r_dn1;
      if (w_cap) begin
        r_start <= w_start;
        r_end   <= w_end_c;
        r_last  <= data_in[0];
        if (data_in[0]) begin
          r_last_idx   <= r_idx;
          r_last_valid <= 1'b1;
        end
      end
    end
  end

  assign ram_counter = r_idx;
  assign addr        = r_addr;
  assign load        = (r_state == S_LOAD);
  assign at_end      = (r_state != S_FETCH) && w_eq;
  assign addr_inc    = w_inc;
  assign seq_wrap    = r_wrap;
  assign done        = r_done;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: a RAM_LAT=1 instance carries the scenarios,
// a RAM_LAT=3 instance shares the stimulus for the latency comparison.
module tb_seq_player;

  localparam int AW = 10;
  localparam int TW = 7;
  localparam int EW = 2*AW+1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          pb_seq_up, pb_seq_dn, pause;
  logic [1:0]    mode;
  logic [EW-1:0] mem [0:(1<<TW)-1];

  logic [EW-1:0] din1;
  logic [TW-1:0] rc1;
  logic [AW-1:0] addr1;
  logic          load1, inc1, end1, wrap1, done1;

  logic [EW-1:0] din3;
  logic [TW-1:0] rc3, rc3_q1, rc3_q2;
  logic [AW-1:0] addr3;
  logic          load3, inc3, end3, wrap3, done3;

  assign din1 = mem[rc1];
  assign din3 = mem[rc3_q2];
  always_ff @(posedge clk) begin
    rc3_q1 <= rc3;
    rc3_q2 <= rc3_q1;
  end

  seq_player #(.ADDR_W(AW), .TAG_AW(TW), .RAM_LAT(1)) u_d1 (
    .clock_n(clk), .reset(reset), .data_in(din1),
    .pb_seq_up(pb_seq_up), .pb_seq_dn(pb_seq_dn),
    .mode(mode), .pause(pause), .ram_counter(rc1),
    .addr(addr1), .load(load1), .addr_inc(inc1),
    .at_end(end1), .seq_wrap(wrap1), .done(done1)
  );

  seq_player #(.ADDR_W(AW), .TAG_AW(TW), .RAM_LAT(3)) u_d3 (
    .clock_n(clk), .reset(reset), .data_in(din3),
    .pb_seq_up(pb_seq_up), .pb_seq_dn(pb_seq_dn),
    .mode(mode), .pause(pause), .ram_counter(rc3),
    .addr(addr3), .load(load3), .addr_inc(inc3),
    .at_end(end3), .seq_wrap(wrap3), .done(done3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input int n);
    for (int k = 0; k < n && !load1; k++) tick();
    chk("load_seen", load1, 1);
  endtask

  task automatic do_req(input logic up, input logic dn, input int e_idx,
                        input int e_start, input logic e_wrap);
    pb_seq_up = up;
    pb_seq_dn = dn;
    tick();
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
    tick();
    chk("req_idx", rc1, e_idx);
    chk("req_wrap", wrap1, e_wrap);
    wait_load(8);
    chk("req_start", addr1, e_start);
  endtask

  int c1, c3, nl;
  int starts [4] = '{6, 13, 22, 43};

  initial begin
    for (int i = 0; i < (1<<TW); i++) mem[i] = '0;
    mem[0] = {10'd0,  10'd5,  1'b0};
    mem[1] = {10'd6,  10'd12, 1'b0};
    mem[2] = {10'd13, 10'd21, 1'b0};
    mem[3] = {10'd22, 10'd42, 1'b0};
    mem[4] = {10'd43, 10'd63, 1'b1};
    reset = 1'b1; pb_seq_up = 1'b0; pb_seq_dn = 1'b0;
    pause = 1'b0; mode = 2'b00;
    repeat (3) tick();
    chk("rst_outs", {addr1, load1, inc1, end1, wrap1, done1, rc1}, 0);
    chk("rst_outs3", {addr3, load3, inc3, end3, wrap3, done3, rc3}, 0);

    reset = 1'b0;
    c1 = 0; c3 = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (load1 && c1 == 0) begin
        c1 = c;
        chk("rst_load_addr", addr1, 0);
      end
      if (load3 && c3 == 0) c3 = c;
    end
    chk("lat1_load_cyc", c1, 1);
    chk("lat3_load_cyc", c3, 3);

    for (int k = 0; k < 10 && !end1; k++) tick();
    chk("loop_end_addr", addr1, 5);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("loop_addr", addr1, i % 6);
      chk("loop_at_end", end1, (i % 6) == 5);
      chk("loop_noload", load1, 0);
      chk("inc_and_end", inc1 & end1, 0);
    end

    do_req(1'b0, 1'b1, 0, 0, 1'b0);
    do_req(1'b1, 1'b0, 1, 6, 1'b0);
    do_req(1'b1, 1'b0, 2, 13, 1'b0);
    do_req(1'b1, 1'b0, 3, 22, 1'b0);
    do_req(1'b1, 1'b0, 4, 43, 1'b0);
    do_req(1'b1, 1'b0, 0, 0, 1'b1);
    do_req(1'b0, 1'b1, 4, 43, 1'b1);

    pb_seq_up = 1'b1; pb_seq_dn = 1'b1;
    tick();
    pb_seq_up = 1'b0; pb_seq_dn = 1'b0;
    tick();
    chk("both_idx", rc1, 4);
    for (int i = 0; i < 4; i++) begin
      chk("both_noload", load1, 0);
      chk("both_inc", inc1, 1);
      tick();
    end

    nl = 0;
    pb_seq_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load1) nl++;
    end
    pb_seq_up = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load1) nl++;
    end
    chk("held_loads", nl, 1);
    chk("held_idx", rc1, 0);

    mode = 2'b01;
    do_req(1'b1, 1'b0, 1, 6, 1'b0);
    for (int k = 0; k < 40 && !done1; k++) tick();
    chk("oneshot_done", done1, 1);
    chk("oneshot_addr", addr1, 12);
    chk("oneshot_end", end1, 1);
    repeat (3) tick();
    chk("oneshot_hold", addr1, 12);

    mode = 2'b11;
    do_req(1'b0, 1'b1, 0, 0, 1'b0);
    chk("dn_clr_done", done1, 0);
    nl = 0;
    for (int k = 0; k < 200 && !done1; k++) begin
      tick();
      if (load1) begin
        if (nl < 4) chk("auto_start", addr1, starts[nl]);
        nl++;
      end
    end
    chk("auto_loads", nl, 4);
    chk("auto_done", done1, 1);
    chk("auto_addr", addr1, 63);
    chk("auto_idx", rc1, 4);

    mode = 2'b00;
    do_req(1'b1, 1'b0, 0, 0, 1'b1);
    chk("up_clr_done", done1, 0);

    for (int k = 0; k < 20 && addr1 != 3; k++) tick();
    chk("pause_at3", addr1, 3);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pause_addr", addr1, 3);
      chk("pause_inc", inc1, 0);
    end
    pause = 1'b0;
    tick();
    chk("unpause_addr", addr1, 4);

    do_req(1'b1, 1'b0, 1, 6, 1'b0);
    do_req(1'b1, 1'b0, 2, 13, 1'b0);
    do_req(1'b1, 1'b0, 3, 22, 1'b0);
    for (int k = 0; k < 20 && addr1 != 30; k++) tick();
    chk("pre_rst_addr", addr1, 30);
    reset = 1'b1;
    tick();
    chk("mid_rst", {addr1, load1, done1, wrap1, rc1}, 0);
    reset = 1'b0;
    tick();
    chk("reload_load", load1, 1);
    chk("reload_addr", addr1, 0);
    do_req(1'b0, 1'b1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
